// File: rtl/poly_div_31by16.sv
`default_nettype none
// ============================================================================
// Module      : poly_div_31by16
// Description : Sequential GF(2) polynomial divider. Divides a 31-bit
//               dividend by a 16-bit divisor, one dividend bit per cycle,
//               MSB first, producing quotient q and remainder r with
//               a = q*b XOR r and deg(r) < deg(b).
// Revision    : 1.0 - initial release
// ============================================================================
module poly_div_31by16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [30:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [30:0] q,
  output logic [14:0] r
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Step index of the 31st (final) CALC step
  localparam logic [4:0] C_LAST_STEP = 5'd30;

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;

  logic [30:0] r_dvd;      // dividend, shifted left so bit 30 is the next bit
  logic [14:0] r_dvs;      // divisor low bits; bit 15 only ever cancels T[15]
  logic [3:0]  r_deg;      // degree of the divisor
  logic [4:0]  r_cnt;      // CALC step counter
  logic [30:0] r_quo;      // quotient accumulator
  logic [14:0] r_rem;      // running remainder

  logic        w_accept;
  logic        w_last;
  logic        w_b_zero;
  logic [3:0]  w_deg_in;
  logic [15:0] w_t;
  logic        w_qbit;
  logic [14:0] w_rem_next;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_cnt == C_LAST_STEP);
  assign w_b_zero = (b == 16'd0);

  // Degree of the incoming divisor: index of its highest set bit
  always_comb begin
    w_deg_in = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) w_deg_in = 4'(i);
    end
  end

  // One long-division step: shift in the next dividend bit, reduce if T[d] set
  always_comb begin
    w_t        = {r_rem, r_dvd[30]};
    w_qbit     = w_t[r_deg];
    w_rem_next = w_t[14:0] ^ (w_qbit ? r_dvs : 15'd0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a zero divisor bypasses CALC entirely
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = w_b_zero ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_CALC:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, per-step update, result publication at DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= 31'd0;
      r_dvs <= 15'd0;
      r_deg <= 4'd0;
      r_cnt <= 5'd0;
      r_quo <= 31'd0;
      r_rem <= 15'd0;
      q     <= 31'd0;
      r     <= 15'd0;
      err   <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= a;
      r_dvs <= b[14:0];
      r_deg <= w_deg_in;
      r_cnt <= 5'd0;
      r_quo <= 31'd0;
      r_rem <= 15'd0;
      if (w_b_zero) begin
        q   <= 31'd0;
        r   <= 15'd0;
        err <= 1'b1;
      end
    end else if (r_state == S_CALC) begin
      r_dvd <= {r_dvd[29:0], 1'b0};
      r_quo <= {r_quo[29:0], w_qbit};
      r_rem <= w_rem_next;
      r_cnt <= r_cnt + 5'd1;
      if (w_last) begin
        q   <= {r_quo[29:0], w_qbit};
        r   <= w_rem_next;
        err <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_div_31by16.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_div_31by16
// Description : Directed self-checking bench for poly_div_31by16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_div_31by16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [30:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic        err;
  logic [30:0] q;
  logic [14:0] r;

  int checks;
  int failures;

  poly_div_31by16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .q     (q),
    .r     (r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Carry-less product of two 16-bit polynomials
  function automatic logic [30:0] clmul(input logic [15:0] x, input logic [15:0] y);
    logic [30:0] p;
    p = 31'd0;
    for (int i = 0; i < 16; i++) begin
      if (y[i]) p = p ^ ({15'd0, x} << i);
    end
    return p;
  endfunction

  // Launch one division, scramble the inputs after acceptance, and wait for done.
  // lat counts negedges from acceptance to the done cycle (40 = timed out).
  task automatic run_op(input logic [30:0] ai, input logic [15:0] bi,
                        output int lat, output int busy_cyc,
                        output logic [30:0] oq, output logic [14:0] orr, output logic oerr);
    @(negedge clk);
    a = ai; b = bi; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~ai; b = ~bi;
    lat = 1; busy_cyc = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    oq = q; orr = r; oerr = err;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      failures++; $display("FAIL reset_flags: got busy/done/err=%b required 000", {busy, done, err});
    end
    checks++;
    if (q !== 31'd0) begin failures++; $display("FAIL reset_q: got %h required 0", q); end
    checks++;
    if (r !== 15'd0) begin failures++; $display("FAIL reset_r: got %h required 0", r); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc; logic [30:0] oq; logic [14:0] orr; logic oerr;
    run_op(31'h13, 16'h3, lat, bc, oq, orr, oerr);
    checks++;
    if (lat !== 32) begin failures++; $display("FAIL basic_latency: got %0d required 32", lat); end
    checks++;
    if (bc !== 31) begin failures++; $display("FAIL basic_busy_cycles: got %0d required 31", bc); end
    checks++;
    if (oq !== 31'hE) begin failures++; $display("FAIL basic_q: got %h required 0000000e", oq); end
    checks++;
    if (orr !== 15'h1) begin failures++; $display("FAIL basic_r: got %h required 0001", orr); end
    checks++;
    if (oerr !== 1'b0) begin failures++; $display("FAIL basic_err: got %b required 0", oerr); end
    @(negedge clk); @(negedge clk);
    checks++;
    if ({busy, done, q, r} !== {2'b00, 31'hE, 15'h1}) begin
      failures++; $display("FAIL basic_hold: got busy=%b done=%b q=%h r=%h required 0 0 e 1", busy, done, q, r);
    end
  endtask

  task automatic test_max_and_unit();
    int lat, bc; logic [30:0] oq; logic [14:0] orr; logic oerr;
    run_op(31'h7FFFFFFF, 16'h8000, lat, bc, oq, orr, oerr);
    checks++;
    if ({oq, orr, oerr} !== {31'h0000FFFF, 15'h7FFF, 1'b0} || lat !== 32) begin
      failures++; $display("FAIL max_div: got q=%h r=%h err=%b lat=%0d required 0000ffff 7fff 0 32", oq, orr, oerr, lat);
    end
    run_op(31'h12345678, 16'h0001, lat, bc, oq, orr, oerr);
    checks++;
    if ({oq, orr, oerr} !== {31'h12345678, 15'h0, 1'b0} || lat !== 32) begin
      failures++; $display("FAIL unit_div: got q=%h r=%h err=%b lat=%0d required 12345678 0 0 32", oq, orr, oerr, lat);
    end
  endtask

  task automatic test_reset_mid_calc();
    int lat, bc; logic [30:0] oq; logic [14:0] orr; logic oerr;
    @(negedge clk);
    a = 31'h7ABCDEF1; b = 16'h00A5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midcalc_busy: got %b required 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err, q, r} !== 49'd0) begin
      failures++; $display("FAIL midcalc_reset: got busy=%b done=%b err=%b q=%h r=%h required all 0", busy, done, err, q, r);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(31'h5, 16'h3, lat, bc, oq, orr, oerr);
    checks++;
    if ({oq, orr, oerr} !== {31'h3, 15'h0, 1'b0} || lat !== 32) begin
      failures++; $display("FAIL post_reset_div: got q=%h r=%h err=%b lat=%0d required 3 0 0 32", oq, orr, oerr, lat);
    end
  endtask

  task automatic test_zero_div();
    @(negedge clk);
    a = 31'h1234; b = 16'h0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // start remains high through the DONE cycle and must be ignored
    checks++;
    if ({done, busy, err, q, r} !== {3'b101, 31'd0, 15'd0}) begin
      failures++; $display("FAIL zero_div: got done=%b busy=%b err=%b q=%h r=%h required 1 0 1 0 0", done, busy, err, q, r);
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done, err} !== 3'b001) begin
      failures++; $display("FAIL zero_div_start_ignored: got busy/done/err=%b required 001", {busy, done, err});
    end
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL zero_div_idle: got busy/done=%b required 00", {busy, done});
    end
  endtask

  task automatic test_roundtrip();
    int lat, bc; logic [30:0] oq; logic [14:0] orr; logic oerr;
    logic [15:0] x, y, e_mask; logic [14:0] e; int d;
    for (int n = 0; n < 40; n++) begin
      x = 16'($urandom);
      y = (n == 0) ? 16'h0001 : (n == 1) ? 16'h8001 : 16'($urandom_range(1, 65535));
      d = 0;
      for (int i = 0; i < 16; i++) if (y[i]) d = i;
      e_mask = (16'd1 << d) - 16'd1;
      e = (n % 2 == 0) ? 15'd0 : 15'($urandom) & e_mask[14:0];
      run_op(clmul(x, y) ^ {16'd0, e}, y, lat, bc, oq, orr, oerr);
      checks++;
      if ({oq, orr, oerr} !== {15'd0, x, e, 1'b0} || lat !== 32) begin
        failures++;
        $display("FAIL roundtrip[%0d]: x=%h y=%h got q=%h r=%h err=%b lat=%0d required q=%h r=%h err=0 lat=32",
                 n, x, y, oq, orr, oerr, lat, x, e);
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_basic();
    test_max_and_unit();
    test_reset_mid_calc();
    test_zero_div();
    test_roundtrip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
